// File: rtl/la_pkg.sv
// Shared types and register map for the logic-analyzer capture core.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package la_pkg;

    // Capture state machine; encodings are visible to the host via offset 0.
    typedef enum logic [2:0] {
        IDLE             = 3'd0,
        MOVE_TO_POSITION = 3'd1,
        IN_POSITION      = 3'd2,
        CAPTURING        = 3'd3,
        CAPTURED         = 3'd4
    } la_state_t;

    // Register offsets relative to BASE_ADDR.
    localparam logic [15:0] STATE_OFS     = 16'd0;
    localparam logic [15:0] REQ_OFS       = 16'd1;
    localparam logic [15:0] TRIG_VAL_OFS  = 16'd2;
    localparam logic [15:0] TRIG_MASK_OFS = 16'd3;
    localparam logic [15:0] TRIG_LOC_OFS  = 16'd4;
    localparam logic [15:0] READ_PTR_OFS  = 16'd5;
    localparam logic [15:0] SAMPLE_OFS    = 16'd6;

endpackage

// File: rtl/la_bus_if.sv
// Daisy-chained 16-bit register bus: inbound request and forwarded/response side.
// Latency: n/a (wiring only).
// Backpressure: none; the chain never stalls.
interface la_bus_if;
    logic [15:0] addr_i;
    logic [15:0] data_i;
    logic        rw_i;
    logic        valid_i;
    logic [15:0] addr_o;
    logic [15:0] data_o;
    logic        rw_o;
    logic        valid_o;

    // The core sits on the chain: consumes *_i, produces *_o.
    modport slave (
        input  addr_i, data_i, rw_i, valid_i,
        output addr_o, data_o, rw_o, valid_o
    );

    // Upstream driver / downstream observer view.
    modport master (
        output addr_i, data_i, rw_i, valid_i,
        input  addr_o, data_o, rw_o, valid_o
    );
endinterface

// File: rtl/la_sample_mem.sv
// Simple dual-port sample RAM: port A writes, port B reads synchronously.
// Latency: 1 cycle from read enable to dout_b.
// Backpressure: none; both ports accept every cycle.
module la_sample_mem #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_a,
    input  logic [AW-1:0]    addr_a,
    input  logic [WIDTH-1:0] din_a,
    input  logic             re_b,
    input  logic [AW-1:0]    addr_b,
    output logic [WIDTH-1:0] dout_b
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Capture write port; no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we_a) begin
            mem[addr_a] <= din_a;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (re_b) begin
            dout_b <= mem[addr_b];
        end
    end
endmodule

// File: rtl/la_capture_core.sv
// Bus-attached logic analyzer: circular probe capture around a masked-equality trigger.
// Latency: bus pass-through and register/sample reads all 1 cycle.
// Backpressure: none; every bus beat is forwarded, capture never stalls.
module la_capture_core
    import la_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR    = 16'd0,
    parameter int          PROBE_WIDTH  = 8,
    parameter int          SAMPLE_DEPTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PROBE_WIDTH-1:0] probe,
    la_bus_if.slave                bus
);
    localparam int              AW       = $clog2(SAMPLE_DEPTH);
    localparam int              CW       = AW + 1;
    localparam logic [16:0]     LAST_OFS = 17'(READ_PTR_OFS) + 17'(SAMPLE_DEPTH);
    localparam logic [15:0]     LOC_MAX  = 16'(SAMPLE_DEPTH - 1);
    localparam logic [CW-1:0]   DEPTH_C  = CW'(SAMPLE_DEPTH);

    la_state_t              state_q, state_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          read_ptr_q, read_ptr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [CW-1:0]          post_target;
    logic [AW-1:0]          trig_loc_q;
    logic [PROBE_WIDTH-1:0] trig_val_q, trig_mask_q;

    logic [15:0]            ofs;
    logic [15:0]            reg_rdata;
    logic                   owned, is_sample, wr_en, rd_en, req_wr, trig_hit;

    logic                   mem_we, mem_re;
    logic [AW-1:0]          mem_raddr;
    logic [PROBE_WIDTH-1:0] mem_dout;

    logic [15:0]            addr_q, data_q;
    logic                   rw_q, valid_q, samp_sel_q;

    // Address decode; addresses below BASE_ADDR wrap high and fall outside the window.
    assign ofs       = bus.addr_i - BASE_ADDR;
    assign owned     = ({1'b0, ofs} <= LAST_OFS);
    assign is_sample = (ofs >= SAMPLE_OFS);
    assign wr_en     = bus.valid_i & bus.rw_i & owned;
    assign rd_en     = bus.valid_i & ~bus.rw_i & owned;
    assign req_wr    = wr_en & (ofs == REQ_OFS);

    assign trig_hit    = ((probe ^ trig_val_q) & trig_mask_q) == '0;
    // Samples still to store from the trigger sample onward.
    assign post_target = DEPTH_C - {1'b0, trig_loc_q};

    // Sample window is presented oldest first, rotated by read_ptr.
    assign mem_raddr = read_ptr_q + AW'(ofs - SAMPLE_OFS);
    assign mem_re    = rd_en & is_sample & (state_q == CAPTURED);

    la_sample_mem #(
        .WIDTH (PROBE_WIDTH),
        .DEPTH (SAMPLE_DEPTH)
    ) u_mem (
        .clk    (clk),
        .we_a   (mem_we),
        .addr_a (wr_ptr_q),
        .din_a  (probe),
        .re_b   (mem_re),
        .addr_b (mem_raddr),
        .dout_b (mem_dout)
    );

    // Register read mux, zero-extended to bus width.
    always_comb begin
        reg_rdata = '0;
        case (ofs)
            STATE_OFS:     reg_rdata = 16'(state_q);
            TRIG_VAL_OFS:  reg_rdata = 16'(trig_val_q);
            TRIG_MASK_OFS: reg_rdata = 16'(trig_mask_q);
            TRIG_LOC_OFS:  reg_rdata = 16'(trig_loc_q);
            READ_PTR_OFS:  reg_rdata = 16'(read_ptr_q);
            default:       reg_rdata = '0;
        endcase
    end

    // Next-state and capture control; host request writes override everything.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        read_ptr_d = read_ptr_q;
        cnt_d      = cnt_q;
        mem_we     = 1'b0;
        case (state_q)
            MOVE_TO_POSITION: begin
                if (trig_loc_q == '0) begin
                    state_d = IN_POSITION;
                end else begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    // Move on as the last pre-trigger sample lands so storage stays gapless.
                    if (cnt_q + 1'b1 == {1'b0, trig_loc_q}) begin
                        state_d = IN_POSITION;
                    end
                end
            end
            IN_POSITION: begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (trig_hit) begin
                    cnt_d = CW'(1);
                    if (post_target == CW'(1)) begin
                        // Trigger sample alone fills the post-trigger window.
                        state_d    = CAPTURED;
                        read_ptr_d = wr_ptr_q + 1'b1;
                    end else begin
                        state_d = CAPTURING;
                    end
                end
            end
            CAPTURING: begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q + 1'b1 == post_target) begin
                    state_d    = CAPTURED;
                    read_ptr_d = wr_ptr_q + 1'b1;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase

        if (req_wr) begin
            if (!bus.data_i[0]) begin
                state_d    = IDLE;
                read_ptr_d = read_ptr_q;
                mem_we     = 1'b0;
            end else if (state_q == IDLE || state_q == CAPTURED) begin
                state_d  = MOVE_TO_POSITION;
                wr_ptr_d = '0;
                cnt_d    = '0;
            end
        end
    end

    // Capture state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            read_ptr_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            read_ptr_q <= read_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    // Trigger configuration, frozen outside IDLE; trig_loc saturates at depth-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_val_q  <= '0;
            trig_mask_q <= '0;
            trig_loc_q  <= '0;
        end else if (wr_en && state_q == IDLE) begin
            case (ofs)
                TRIG_VAL_OFS:  trig_val_q  <= bus.data_i[PROBE_WIDTH-1:0];
                TRIG_MASK_OFS: trig_mask_q <= bus.data_i[PROBE_WIDTH-1:0];
                TRIG_LOC_OFS:  trig_loc_q  <= (bus.data_i > LOC_MAX) ? LOC_MAX[AW-1:0]
                                                                     : bus.data_i[AW-1:0];
                default:       trig_val_q  <= trig_val_q;
            endcase
        end
    end

    // Bus output stage: forward everything, substitute read data for owned reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            data_q     <= '0;
            rw_q       <= 1'b0;
            valid_q    <= 1'b0;
            samp_sel_q <= 1'b0;
        end else begin
            addr_q     <= bus.addr_i;
            rw_q       <= bus.rw_i;
            valid_q    <= bus.valid_i;
            samp_sel_q <= mem_re;
            if (rd_en && is_sample) begin
                data_q <= '0;
            end else if (rd_en) begin
                data_q <= reg_rdata;
            end else begin
                data_q <= bus.data_i;
            end
        end
    end

    // RAM output arrives one cycle after the read, aligned with the output stage.
    assign bus.addr_o  = addr_q;
    assign bus.data_o  = samp_sel_q ? 16'(mem_dout) : data_q;
    assign bus.rw_o    = rw_q;
    assign bus.valid_o = valid_q;

endmodule

// File: tb/tb_la_capture_core.sv
// Directed bench for la_capture_core: register table plus capture scenarios.
// Latency: bus ops take one cycle, sampled on the falling edge.
// Backpressure: none modelled.
module tb_la_capture_core;
    localparam logic [15:0] B = 16'h0100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] probe = 8'h00;
    logic       pload_en = 1'b0;
    logic [7:0] pload_val = 8'h00;
    int         checks = 0;
    int         errors = 0;

    la_bus_if bus ();

    la_capture_core #(
        .BASE_ADDR    (B),
        .PROBE_WIDTH  (8),
        .SAMPLE_DEPTH (64)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .probe (probe),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Free-running probe counter, loadable so captures have known contents.
    always @(posedge clk) probe <= pload_en ? pload_val : probe + 8'd1;

    typedef struct {
        logic        rw;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [24];

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Entered and left on a falling edge.
    task automatic bus_op(input logic rw, input logic [15:0] a, input logic [15:0] d,
                          output logic [15:0] q, output logic [15:0] aq,
                          output logic v, output logic rwq);
        bus.addr_i  = a;
        bus.data_i  = d;
        bus.rw_i    = rw;
        bus.valid_i = 1'b1;
        @(negedge clk);
        q   = bus.data_o;
        aq  = bus.addr_o;
        v   = bus.valid_o;
        rwq = bus.rw_o;
        bus.addr_i  = '0;
        bus.data_i  = '0;
        bus.rw_i    = 1'b0;
        bus.valid_i = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        logic [15:0] q, aq;
        logic v, r;
        bus_op(1'b1, a, d, q, aq, v, r);
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string nm);
        logic [15:0] q, aq;
        logic v, r;
        bus_op(1'b0, a, 16'h0000, q, aq, v, r);
        check(nm, q, exp);
    endtask

    task automatic arm(input logic [7:0] first);
        pload_en  = 1'b1;
        pload_val = first;
        wr(B + 16'd1, 16'h0001);
        pload_en  = 1'b0;
    endtask

    task automatic wait_state(input logic [15:0] want, input int limit, input string nm);
        logic [15:0] q, aq;
        logic v, r;
        bit ok;
        ok = 1'b0;
        q  = '0;
        for (int n = 0; n < limit && !ok; n++) begin
            bus_op(1'b0, B, 16'h0000, q, aq, v, r);
            if (q == want) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s state_last=%0d expected=%0d within %0d reads", nm, q, want, limit);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation timed out");
    end

    initial begin
        logic [15:0] q, aq;
        logic v, r;

        bus.addr_i = '0; bus.data_i = '0; bus.rw_i = 1'b0; bus.valid_i = 1'b0;

        vecs[0]  = '{1'b0, B + 16'd0,   16'h0000, 16'h0000, "rst_state"};
        vecs[1]  = '{1'b0, B + 16'd2,   16'h0000, 16'h0000, "rst_trig_val"};
        vecs[2]  = '{1'b0, B + 16'd3,   16'h0000, 16'h0000, "rst_trig_mask"};
        vecs[3]  = '{1'b0, B + 16'd4,   16'h0000, 16'h0000, "rst_trig_loc"};
        vecs[4]  = '{1'b0, B + 16'd5,   16'h0000, 16'h0000, "rst_read_ptr"};
        vecs[5]  = '{1'b0, B + 16'd100, 16'h1234, 16'h1234, "pass_rd"};
        vecs[6]  = '{1'b0, B - 16'd1,   16'h5A5A, 16'h5A5A, "below_base"};
        vecs[7]  = '{1'b0, B + 16'd70,  16'hBEEF, 16'hBEEF, "above_range"};
        vecs[8]  = '{1'b0, B + 16'd6,   16'h1111, 16'h0000, "idle_sample_first"};
        vecs[9]  = '{1'b0, B + 16'd69,  16'h2222, 16'h0000, "idle_sample_last"};
        vecs[10] = '{1'b1, B + 16'd2,   16'h01AB, 16'h01AB, "wr_val_fwd"};
        vecs[11] = '{1'b0, B + 16'd2,   16'h0000, 16'h00AB, "trig_val_trunc"};
        vecs[12] = '{1'b1, B + 16'd3,   16'h00FF, 16'h00FF, "wr_mask_fwd"};
        vecs[13] = '{1'b0, B + 16'd3,   16'h0000, 16'h00FF, "trig_mask_rd"};
        vecs[14] = '{1'b1, B + 16'd4,   16'hFFFF, 16'hFFFF, "wr_loc_fwd"};
        vecs[15] = '{1'b0, B + 16'd4,   16'h0000, 16'h003F, "trig_loc_clamp"};
        vecs[16] = '{1'b1, B + 16'd4,   16'h0010, 16'h0010, "wr_loc16"};
        vecs[17] = '{1'b0, B + 16'd4,   16'h0000, 16'h0010, "trig_loc_rd"};
        vecs[18] = '{1'b1, B + 16'd5,   16'h0077, 16'h0077, "wr_read_ptr"};
        vecs[19] = '{1'b0, B + 16'd5,   16'h0000, 16'h0000, "read_ptr_ro"};
        vecs[20] = '{1'b1, B + 16'd0,   16'h0003, 16'h0003, "wr_state"};
        vecs[21] = '{1'b0, B + 16'd0,   16'h0000, 16'h0000, "state_ro"};
        vecs[22] = '{1'b1, B + 16'd1,   16'h0000, 16'h0000, "req0_idle"};
        vecs[23] = '{1'b0, B + 16'd0,   16'h0000, 16'h0000, "req0_idle_state"};

        // Reset values of the bus outputs.
        repeat (3) @(negedge clk);
        check("rst_valid_o", {15'd0, bus.valid_o}, 16'h0000);
        check("rst_addr_o", bus.addr_o, 16'h0000);
        check("rst_data_o", bus.data_o, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);

        // Register map, pass-through and width rules.
        for (int i = 0; i < 24; i++) begin
            bus_op(vecs[i].rw, vecs[i].addr, vecs[i].wdata, q, aq, v, r);
            check(vecs[i].name, q, vecs[i].exp);
            check({vecs[i].name, "_addr"}, aq, vecs[i].addr);
            check({vecs[i].name, "_valid"}, {15'd0, v}, 16'h0001);
            check({vecs[i].name, "_rw"}, {15'd0, r}, {15'd0, vecs[i].rw});
        end

        // Immediate trigger: mask 0, no pre-trigger samples.
        wr(B + 16'd3, 16'h0000);
        wr(B + 16'd4, 16'h0000);
        arm(8'h0F);
        wait_state(16'd4, 200, "imm_captured");
        rd(B + 16'd5, 16'h0000, "imm_read_ptr");
        for (int i = 0; i < 64; i++) begin
            rd(B + 16'd6 + 16'(i), 16'h0010 + 16'(i), "imm_sample");
        end

        // Pre-trigger window of 16 samples around value 0x80.
        wr(B + 16'd1, 16'h0000);
        wr(B + 16'd2, 16'h0080);
        wr(B + 16'd3, 16'h00FF);
        wr(B + 16'd4, 16'h0010);
        arm(8'h00);
        wait_state(16'd4, 400, "pre_captured");
        rd(B + 16'd5, 16'd48, "pre_read_ptr");
        rd(B + 16'd6 + 16'd16, 16'h0080, "pre_s16");
        rd(B + 16'd6 + 16'd15, 16'h007F, "pre_s15");
        rd(B + 16'd6,          16'h0070, "pre_s0");
        rd(B + 16'd6 + 16'd63, 16'h00AF, "pre_s63");

        // Re-arm straight from CAPTURED with a different start phase.
        arm(8'h41);
        wait_state(16'd1, 4, "rearm_moving");
        wait_state(16'd4, 400, "rearm_captured");
        rd(B + 16'd5, 16'd47, "rearm_read_ptr");
        rd(B + 16'd6,          16'h0070, "rearm_s0");
        rd(B + 16'd6 + 16'd16, 16'h0080, "rearm_s16");
        rd(B + 16'd6 + 16'd63, 16'h00AF, "rearm_s63");

        // Long wait before trigger: buffer wraps several times.
        wr(B + 16'd1, 16'h0000);
        wr(B + 16'd2, 16'h00C8);
        arm(8'h00);
        wait_state(16'd4, 600, "wrap_captured");
        rd(B + 16'd5, 16'd56, "wrap_read_ptr");
        for (int i = 0; i < 64; i++) begin
            rd(B + 16'd6 + 16'(i), 16'h00B8 + 16'(i), "wrap_sample");
        end

        // Abort while waiting for the trigger.
        arm(8'h00);
        wait_state(16'd2, 50, "abort_in_position");
        wr(B + 16'd1, 16'h0000);
        rd(B + 16'd0, 16'h0000, "abort_state");
        rd(B + 16'd5, 16'd56, "abort_read_ptr_kept");
        wr(B + 16'd2, 16'h003C);
        rd(B + 16'd2, 16'h003C, "abort_val_writable");
        rd(B + 16'd6, 16'h0000, "abort_sample_zero");

        // Config locked while capturing, then reset mid-capture.
        wr(B + 16'd2, 16'h0020);
        arm(8'h00);
        wait_state(16'd3, 100, "lock_capturing");
        wr(B + 16'd2, 16'h0055);
        rd(B + 16'd2, 16'h0020, "lock_val_unchanged");
        rd(B + 16'd0, 16'h0003, "lock_still_capturing");
        bus.addr_i  = B + 16'd200;
        bus.valid_i = 1'b1;
        @(negedge clk);
        check("pre_rst_valid_o", {15'd0, bus.valid_o}, 16'h0001);
        rst_n = 1'b0;
        #1;
        check("midrst_valid_o", {15'd0, bus.valid_o}, 16'h0000);
        check("midrst_addr_o", bus.addr_o, 16'h0000);
        bus.valid_i = 1'b0;
        bus.addr_i  = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd(B + 16'd0, 16'h0000, "midrst_state");
        rd(B + 16'd2, 16'h0000, "midrst_trig_val");
        rd(B + 16'd4, 16'h0000, "midrst_trig_loc");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
